memory_page_reader: RTL and testbench
=====================================

// Module: memory_page_reader
// PURPOSE
// - Drains one event page of a Memory block (sync-read RAM: OUT valid the cycle after READ_ADD) into a valid/ready stream.
// - Sits directly downstream of Memory: drives its READ_ADD and consumes its OUT.
// - Absorbs the 1-cycle RAM read latency with a 2-entry skid FIFO; full throughput (1 word/cycle) when READY_IN is held high.
// PARAMETERS
// - RAM_WIDTH      36  data width; matches the attached Memory.
// - RAM_ADDR_BITS  9   Memory address width.
// - PAGE_BITS      2   upper address bits selecting the event page; IDX_BITS = RAM_ADDR_BITS-PAGE_BITS.
// PORTS
// - CLK        in   1                 clock; all logic on posedge.
// - RST_N      in   1                 asynchronous, active-low reset.
// - START      in   1                 1-cycle pulse: begin draining a page; ignored while BUSY=1.
// - PAGE       in   PAGE_BITS         page to read; sampled with START.
// - NENTRIES   in   IDX_BITS+1        words to read (0..2**IDX_BITS); sampled with START.
// - READ_ADD   out  RAM_ADDR_BITS     registered; to Memory READ_ADD = {page, idx}.
// - RAM_DATA   in   RAM_WIDTH         from Memory OUT.
// - DATA_OUT   out  RAM_WIDTH         FIFO head word.
// - VALID_OUT  out  1                 DATA_OUT valid.
// - READY_IN   in   1                 consumer accepts; transfer = VALID_OUT & READY_IN.
// - BUSY       out  1                 high from cycle after START until DONE cycle inclusive.
// - DONE       out  1                 1-cycle pulse in the cycle of the last transfer.
// - STALL_CNT  out  16                only with MEMORY_READER_STATS_EN (see CONFIGURATION).
// BEHAVIOUR
// - Reset: READ_ADD=0, VALID_OUT=0, DATA_OUT=0, BUSY=0, DONE=0, FIFO empty, STALL_CNT=0, state IDLE.
// - FSM IDLE -> READ on accepted START with NENTRIES>0. READ -> DRAIN when the last index is issued.
//   DRAIN -> IDLE on the last transfer (DONE=1 that cycle).
// - NENTRIES=0: no reads, no VALID_OUT; DONE=1 and BUSY=1 the cycle after START, then IDLE.
// - Issue: a read is issued in a cycle when READ_ADD presents a new address and the issued flag is set.
//   Word lands on RAM_DATA the next cycle and is written into the FIFO at that cycle's end.
// - Issue rule: issue iff state READ and (fifo_count - pop + inflight) < 2.
//   pop = transfer this cycle; inflight = read issued previous cycle. FIFO never overflows; RAM_DATA is never dropped.
// - Index runs 0..NENTRIES-1, +1 per issue. READ_ADD = {PAGE, idx}. Never crosses into the next page.
//   idx counter is IDX_BITS+1 wide, so NENTRIES=2**IDX_BITS ends at {PAGE, all-ones}.
// - Latency: START at cycle 0 -> READ_ADD=first address at cycle 1 -> VALID_OUT at cycle 3 (READY_IN high).
// - Output order equals address order. DATA_OUT/VALID_OUT come from FIFO head registers, not combinational from RAM_DATA.
// - READY_IN low: VALID_OUT and DATA_OUT hold stable until transfer. Issue stops once the credit rule fails.
// - Simultaneous FIFO push and pop: count unchanged, order preserved.
// - START while BUSY: ignored; PAGE/NENTRIES are not resampled.
// - START in the DONE cycle: ignored. Earliest accepted START is the cycle after DONE.
// - RST_N asserted mid-operation: immediate return to reset values. In-flight RAM word discarded; no DONE.
// CONFIGURATION
// - MEMORY_READER_STATS_EN defined: STALL_CNT port exists.
//   Counts cycles with VALID_OUT=1 & READY_IN=0; saturates at 16'hFFFF; cleared on reset and on accepted START.
// - Not defined: STALL_CNT port and counter logic absent; all other behaviour identical.
// TESTING
// - Reset, then START PAGE=1 NENTRIES=5, READY_IN=1 -> READ_ADD 0x080..0x084 cycles 1-5.
//   RAM words on DATA_OUT cycles 3-7; DONE at cycle 7 only; BUSY cycles 1-7.
// - Same start, READY_IN low cycles 3-6 -> word0 held stable on DATA_OUT 3-6.
//   At most 2 reads issued before stall; no loss or duplication; STALL_CNT=4 (STATS_EN).
// - START NENTRIES=0 -> DONE at cycle 1, VALID_OUT never high, READ_ADD unchanged.
// - START PAGE=1 NENTRIES=128 -> last READ_ADD=0x0FF; 128 transfers; 0x100 never driven.
// - START during BUSY with PAGE=3 -> ignored, original page completes.
//   RST_N low mid-stream -> all outputs 0 asynchronously, no DONE; a new START then works normally.
// - Random READY_IN over 1000 pages, scoreboard vs preloaded RAM -> exact order, one DONE per page.

Source files
------------

// File: rtl/memory_page_reader.sv
// Drains one page of a sync-read RAM into a valid/ready stream.
// Optional STALL_CNT statistics port: define MEMORY_READER_STATS_EN.
module memory_page_reader #(
  parameter int RAM_WIDTH     = 36,
  parameter int RAM_ADDR_BITS = 9,
  parameter int PAGE_BITS     = 2,
  localparam int IDX_BITS     = RAM_ADDR_BITS - PAGE_BITS
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic [PAGE_BITS-1:0]     PAGE,
  input  logic [IDX_BITS:0]        NENTRIES,
  output logic [RAM_ADDR_BITS-1:0] READ_ADD,
  input  logic [RAM_WIDTH-1:0]     RAM_DATA,
  output logic [RAM_WIDTH-1:0]     DATA_OUT,
  output logic                     VALID_OUT,
  input  logic                     READY_IN,
  output logic                     BUSY,
  output logic                     DONE
`ifdef MEMORY_READER_STATS_EN
  ,
  output logic [15:0]              STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    ZERO
  } state_e;

  state_e                   state_q;
  logic [PAGE_BITS-1:0]     page_q;
  logic [IDX_BITS:0]        nent_q;
  logic [IDX_BITS:0]        idx_q;
  logic [IDX_BITS:0]        rem_q;
  logic [RAM_ADDR_BITS-1:0] add_q;
  logic                     inflight_q;
  logic [1:0]               cnt_q;
  logic [RAM_WIDTH-1:0]     d0_q;
  logic [RAM_WIDTH-1:0]     d1_q;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  logic [IDX_BITS:0] idx_d;

  assign VALID_OUT = (cnt_q != 2'd0);
  assign DATA_OUT  = d0_q;
  assign READ_ADD  = add_q;
  assign BUSY      = (state_q != IDLE);

  assign pop  = VALID_OUT & READY_IN;
  assign push = inflight_q;

  // FIFO slots still owed after this cycle, counting the word on RAM_DATA
  assign occ   = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, inflight_q};
  assign issue = (state_q == READ) && (occ < 3'd2);
  assign idx_d = idx_q + 1'b1;

  assign DONE = (state_q == ZERO) ||
                ((state_q == DRAIN) && pop &&
                 (rem_q == {{IDX_BITS{1'b0}}, 1'b1}));

`ifdef MEMORY_READER_STATS_EN
  logic [15:0] stall_q;
  assign STALL_CNT = stall_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
    end else if (state_q == IDLE && START) begin
      stall_q <= '0;
    end else if (VALID_OUT && !READY_IN && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      page_q     <= '0;
      nent_q     <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      add_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
    end else begin
      inflight_q <= issue;
      if (pop) rem_q <= rem_q - 1'b1;

      unique case (state_q)
        IDLE: if (START) begin
          page_q <= PAGE;
          nent_q <= NENTRIES;
          rem_q  <= NENTRIES;
          idx_q  <= '0;
          if (NENTRIES == '0) begin
            state_q <= ZERO;
          end else begin
            state_q <= READ;
            add_q   <= {PAGE, {IDX_BITS{1'b0}}};
          end
        end
        READ: if (issue) begin
          idx_q <= idx_d;
          // Hold the last address so READ_ADD never leaves the page
          if (idx_d == nent_q) state_q <= DRAIN;
          else add_q <= {page_q, idx_d[IDX_BITS-1:0]};
        end
        DRAIN: if (DONE) state_q <= IDLE;
        ZERO:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) d0_q <= RAM_DATA;
          else d1_q <= RAM_DATA;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_q <= RAM_DATA;
          end else begin
            d0_q <= d1_q;
            d1_q <= RAM_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_page_reader.sv
// Scoreboard bench for memory_page_reader with a sync-read RAM model.
// Define MEMORY_READER_STATS_EN to also check STALL_CNT.
module tb_memory_page_reader;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [1:0]  PAGE;
  logic [7:0]  NENTRIES;
  logic [8:0]  READ_ADD;
  logic [35:0] RAM_DATA;
  logic [35:0] DATA_OUT;
  logic        VALID_OUT;
  logic        READY_IN;
  logic        BUSY;
  logic        DONE;
`ifdef MEMORY_READER_STATS_EN
  logic [15:0] STALL_CNT;
`endif

  logic [35:0] mem [512];
  logic [35:0] exq [$];

  int nchk = 0;
  int nerr = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int bad_pg = 0;
  bit watch = 0;
  logic [1:0] watch_pg = '0;

  memory_page_reader dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .PAGE(PAGE),
    .NENTRIES(NENTRIES),
    .READ_ADD(READ_ADD),
    .RAM_DATA(RAM_DATA),
    .DATA_OUT(DATA_OUT),
    .VALID_OUT(VALID_OUT),
    .READY_IN(READY_IN),
    .BUSY(BUSY),
    .DONE(DONE)
`ifdef MEMORY_READER_STATS_EN
    ,
    .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) RAM_DATA <= mem[READ_ADD];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (VALID_OUT && READY_IN) begin
        xfer_cnt++;
        if (exq.size() == 0) chk("xfer_extra", 64'(DATA_OUT), 64'hx);
        else chk("xfer_data", 64'(DATA_OUT), 64'(exq.pop_front()));
      end
      if (DONE) done_cnt++;
      if (watch && READ_ADD[8:7] != watch_pg) bad_pg++;
    end
  end

  // Called at posedge+1; leaves at posedge+1 of the cycle after START
  task automatic start_page(input logic [1:0] p, input logic [7:0] n);
    START = 1'b1;
    PAGE = p;
    NENTRIES = n;
    for (int i = 0; i < int'(n); i++) begin
      logic [8:0] a;
      a = {p, 7'(i)};
      exq.push_back(mem[a]);
    end
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
      @(posedge CLK);
      #1;
      if (rnd) READY_IN = ($urandom_range(0, 3) != 0);
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int x0;
    for (int i = 0; i < 512; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      mem[i] = r[35:0];
    end
    RST_N = 1'b0;
    START = 1'b0;
    PAGE = '0;
    NENTRIES = '0;
    READY_IN = 1'b1;
    #12;
    chk("rst_add", 64'(READ_ADD), 64'd0);
    chk("rst_vld", 64'({VALID_OUT, BUSY, DONE}), 64'd0);
    chk("rst_data", 64'(DATA_OUT), 64'd0);
`ifdef MEMORY_READER_STATS_EN
    chk("rst_stall", 64'(STALL_CNT), 64'd0);
`endif
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Full-throughput page
    d0 = done_cnt;
    start_page(2'd1, 8'd5);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      if (k <= 5) chk("t1_add", 64'(READ_ADD), 64'(9'h080 + 9'(k - 1)));
      chk("t1_done", 64'(DONE), 64'(k == 7));
      chk("t1_busy", 64'(BUSY), 64'(k <= 7));
      chk("t1_vld", 64'(VALID_OUT), 64'(k >= 3 && k <= 7));
      @(posedge CLK);
      #1;
    end
    chk("t1_ndone", 64'(done_cnt - d0), 64'd1);

    // Consumer stall on cycles 3..6
    start_page(2'd1, 8'd5);
    for (int k = 1; k <= 6; k++) begin
      READY_IN = (k < 3);
      @(negedge CLK);
      if (k >= 3) begin
        chk("t2_hold", 64'(DATA_OUT), 64'(mem[9'h080]));
        chk("t2_vld", 64'(VALID_OUT), 64'd1);
      end
      if (k == 6) chk("t2_add", 64'(READ_ADD), 64'h082);
      @(posedge CLK);
      #1;
    end
    READY_IN = 1'b1;
    wait_done(40, 0);
    chk("t2_q", 64'(exq.size()), 64'd0);
`ifdef MEMORY_READER_STATS_EN
    chk("t2_stall", 64'(STALL_CNT), 64'd4);
`endif

    // Empty page
    begin
      logic [8:0] a0;
      a0 = READ_ADD;
      x0 = xfer_cnt;
      start_page(2'd2, 8'd0);
      @(negedge CLK);
      chk("t3_done", 64'({DONE, BUSY}), 64'b11);
      @(posedge CLK);
      #1;
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        chk("t3_idle", 64'({DONE, BUSY, VALID_OUT}), 64'd0);
        @(posedge CLK);
        #1;
      end
      chk("t3_add", 64'(READ_ADD), 64'(a0));
      chk("t3_xfer", 64'(xfer_cnt - x0), 64'd0);
    end

    // Whole page, must not spill into next page
    x0 = xfer_cnt;
    bad_pg = 0;
    start_page(2'd1, 8'd128);
    watch_pg = 2'd1;
    watch = 1;
    wait_done(400, 0);
    watch = 0;
    chk("t4_last", 64'(READ_ADD), 64'h0FF);
    chk("t4_xfer", 64'(xfer_cnt - x0), 64'd128);
    chk("t4_page", 64'(bad_pg), 64'd0);

    // START while busy is ignored
    d0 = done_cnt;
    bad_pg = 0;
    start_page(2'd1, 8'd5);
    watch = 1;
    START = 1'b1;
    PAGE = 2'd3;
    NENTRIES = 8'd4;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done(40, 0);
    watch = 0;
    chk("t5_page", 64'(bad_pg), 64'd0);
    chk("t5_ndone", 64'(done_cnt - d0), 64'd1);
    chk("t5_q", 64'(exq.size()), 64'd0);

    // Reset mid-stream
    d0 = done_cnt;
    start_page(2'd2, 8'd20);
    repeat (6) begin
      @(posedge CLK);
      #1;
    end
    RST_N = 1'b0;
    #1;
    chk("t6_add", 64'(READ_ADD), 64'd0);
    chk("t6_out", 64'({VALID_OUT, BUSY, DONE}), 64'd0);
    chk("t6_data", 64'(DATA_OUT), 64'd0);
    exq.delete();
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("t6_nodone", 64'(done_cnt - d0), 64'd0);
    @(posedge CLK);
    #1;
    start_page(2'd0, 8'd3);
    wait_done(40, 0);
    chk("t6_q", 64'(exq.size()), 64'd0);

    // Random pages with random backpressure
    d0 = done_cnt;
    for (int p = 0; p < 1000; p++) begin
      start_page(2'($urandom_range(0, 3)), 8'($urandom_range(0, 24)));
      wait_done(400, 1);
    end
    chk("rnd_ndone", 64'(done_cnt - d0), 64'd1000);
    chk("rnd_q", 64'(exq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
